// File: rtl/mem_copy_engine.sv
// mem_copy_engine
//   Block-move initiator for the single-port data memory. A start pulse
//   launches either a copy (read source byte, write destination byte) or a
//   fill (write a constant) over a block of len bytes. Pointers wrap modulo
//   2^ADDR_W. All outputs are Moore-decoded from registered state.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, fill           launch request and mode (1 = fill), start sampled in IDLE
//   src_addr, dst_addr    first source / destination address, latched at start
//   len                   byte count, 0 means no memory access
//   fill_val              constant for fill mode, latched at start
//   abort                 early termination, sampled in RD/WR
//   busy, done            busy in RD/WR, done pulses for one cycle on completion
//   mem_addr, mem_read,
//   mem_write, mem_wdata  memory port drive
//   mem_rdata             combinational read data, valid while mem_read is high
//   dbg_state             current FSM state for observation
//
// Handshake: start is a level sampled at a rising edge while IDLE; there is no
// ready/valid pair on the memory side because the memory responds in the same
// cycle (read data combinational, write committed on the closing edge).
module mem_copy_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              fill,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_val,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_rem;
  logic [DATA_W-1:0] r_buf;
  logic              r_fill;
  logic [DATA_W-1:0] r_fill_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      r_rem      <= '0;
      r_buf      <= '0;
      r_fill     <= 1'b0;
      r_fill_val <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src      <= src_addr;
            r_dst      <= dst_addr;
            r_rem      <= len;
            r_fill     <= fill;
            r_fill_val <= fill_val;
            if (len == '0)  r_state <= S_DONE;
            else if (fill)  r_state <= S_WR;
            else            r_state <= S_RD;
          end
        end
        S_RD: begin
          // An aborted read is simply dropped; buf keeps its old value.
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_buf   <= mem_rdata;
            r_state <= S_WR;
          end
        end
        S_WR: begin
          // The write driven this cycle lands on this edge even when aborting.
          if (abort) begin
            r_state <= S_IDLE;
          end else begin
            r_src <= r_src + ADDR_W'(1);
            r_dst <= r_dst + ADDR_W'(1);
            r_rem <= r_rem - ADDR_W'(1);
            if (r_rem == ADDR_W'(1)) r_state <= S_DONE;
            else if (r_fill)         r_state <= S_WR;
            else                     r_state <= S_RD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    case (r_state)
      S_RD: begin
        busy     = 1'b1;
        mem_read = 1'b1;
        mem_addr = r_src;
      end
      S_WR: begin
        busy      = 1'b1;
        mem_write = 1'b1;
        mem_addr  = r_dst;
        mem_wdata = r_fill ? r_fill_val : r_buf;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_mem_copy_engine.sv
module tb_mem_copy_engine;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       fill;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [7:0] len;
  logic [7:0] fill_val;
  logic       abort;
  logic       busy;
  logic       done;
  logic [7:0] mem_addr;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [1:0] dbg_state;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_copy_engine #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fill(fill),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
    .abort(abort), .busy(busy), .done(done), .mem_addr(mem_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // ---------------- memory behind the engine ----------------
  logic [7:0] mem [256];
  logic       pl_we;
  logic [7:0] pl_addr;
  logic [7:0] pl_data;

  always @(posedge clk) begin
    if (pl_we)          mem[pl_addr]  <= pl_data;
    else if (mem_write) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem_read ? mem[mem_addr] : 8'h00;

  // ---------------- reference model state ----------------
  logic [7:0]  exp_mem [256];
  // {busy, done, rd, wr, addr[7:0], wdata[7:0]} per cycle
  logic [19:0] exp_q[$];
  int          busy_cnt;
  int          done_at;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [19:0] mk(input bit b, input bit d, input bit r, input bit w,
                                      input logic [7:0] a, input logic [7:0] wd);
    return {b, d, r, w, a, wd};
  endfunction

  // Build the expected per-cycle trace of one operation and update the model
  // memory. ab > 0 means abort is sampled at the end of cycle ab.
  task automatic plan_op(input bit f, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] n, input logic [7:0] fv, input int ab);
    int c = 0;
    bit cut = 0;
    logic [7:0] data;
    logic [7:0] as_;
    logic [7:0] ad_;
    if (n == 8'd0) begin
      exp_q.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00));
      return;
    end
    for (int i = 0; i < int'(n) && !cut; i++) begin
      as_ = s + 8'(i);
      ad_ = d + 8'(i);
      data = fv;
      if (!f) begin
        c++;
        if (ab > 0 && c > ab) begin cut = 1; break; end
        exp_q.push_back(mk(1, 0, 1, 0, as_, 8'h00));
        data = exp_mem[as_];
      end
      c++;
      if (ab > 0 && c > ab) begin cut = 1; break; end
      exp_q.push_back(mk(1, 0, 0, 1, ad_, data));
      exp_mem[ad_] = data;
      if (ab > 0 && c == ab) cut = 1;
    end
    if (!cut) exp_q.push_back(mk(0, 1, 0, 0, 8'h00, 8'h00));
  endtask

  // ---------------- compare process ----------------
  logic [19:0] e;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd", mem_read, 0);
      chk("rst_wr", mem_write, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cyc_busy", busy, e[19]);
      chk("cyc_done", done, e[18]);
      chk("cyc_rd", mem_read, e[17]);
      chk("cyc_wr", mem_write, e[16]);
      chk("cyc_rw_excl", mem_read & mem_write, 0);
      if (e[17] | e[16]) chk("cyc_addr", mem_addr, e[15:8]);
      if (e[16]) chk("cyc_wdata", mem_wdata, e[7:0]);
    end else begin
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_rd", mem_read, 0);
      chk("idle_wr", mem_write, 0);
      chk("idle_addr", mem_addr, 0);
      chk("idle_wdata", mem_wdata, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    exp_mem[a] = d;
    @(posedge clk); #1;
    pl_we = 1'b0;
  endtask

  // Called at posedge+1 while the engine is IDLE.
  task automatic run_op(input bit f, input logic [7:0] s, input logic [7:0] d,
                        input logic [7:0] n, input logic [7:0] fv, input int ab);
    int nc;
    start = 1'b1; fill = f; src_addr = s; dst_addr = d; len = n; fill_val = fv;
    @(posedge clk); #1;
    start = 1'b0;
    plan_op(f, s, d, n, fv, ab);
    nc = exp_q.size();
    busy_cnt = 0;
    done_at  = 0;
    if (ab > 0) begin
      repeat (ab - 1) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
    end else begin
      for (int c = 1; c <= nc + 2; c++) begin
        @(negedge clk);
        if (busy) busy_cnt++;
        if (done) done_at = c;
      end
      @(posedge clk); #1;
    end
    chk("q_drain", exp_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b1; start = 1'b0; fill = 1'b0; src_addr = '0; dst_addr = '0;
    len = '0; fill_val = '0; abort = 1'b0; pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_state", dbg_state, 0);
    chk("reset_busy", busy, 0);

    for (int i = 0; i < 256; i++) poke(8'(i), 8'(i) ^ 8'h3C);
    poke(8'h10, 8'hA1); poke(8'h11, 8'hB2); poke(8'h12, 8'hC3); poke(8'h13, 8'hD4);

    // Copy 4 bytes.
    run_op(0, 8'h10, 8'h40, 8'd4, 8'h00, 0);
    chk("copy_busy_cycles", busy_cnt, 8);
    chk("copy_done_cycle", done_at, 9);
    chk("copy_d40", mem[8'h40], 8'hA1);
    chk("copy_d41", mem[8'h41], 8'hB2);
    chk("copy_d42", mem[8'h42], 8'hC3);
    chk("copy_d43", mem[8'h43], 8'hD4);
    chk("copy_src_kept", mem[8'h10], 8'hA1);

    // Fill across the wrap point.
    run_op(1, 8'h00, 8'hFE, 8'd3, 8'h5A, 0);
    chk("fill_busy_cycles", busy_cnt, 3);
    chk("fill_done_cycle", done_at, 4);
    chk("fill_fe", mem[8'hFE], 8'h5A);
    chk("fill_ff", mem[8'hFF], 8'h5A);
    chk("fill_00", mem[8'h00], 8'h5A);
    chk("fill_01_kept", mem[8'h01], 8'h3D);

    // Zero length.
    run_op(0, 8'h10, 8'h80, 8'd0, 8'h00, 0);
    chk("zero_done_cycle", done_at, 1);
    chk("zero_busy_cycles", busy_cnt, 0);

    // Abort in the 3rd WR cycle (cycle 6), then start again immediately.
    run_op(0, 8'h10, 8'h60, 8'd8, 8'h00, 6);
    chk("abort_idle", dbg_state, 0);
    run_op(1, 8'h00, 8'h70, 8'd2, 8'hEE, 0);
    chk("abort_restart_done", done_at, 3);
    chk("abort_d60", mem[8'h60], 8'hA1);
    chk("abort_d62", mem[8'h62], 8'hC3);
    chk("abort_d63_kept", mem[8'h63], 8'h5F);
    chk("restart_d71", mem[8'h71], 8'hEE);

    // Overlapping ascending copy propagates the first byte.
    poke(8'h20, 8'h01); poke(8'h21, 8'h02); poke(8'h22, 8'h03); poke(8'h23, 8'h04);
    run_op(0, 8'h20, 8'h21, 8'd3, 8'h00, 0);
    chk("ovl_21", mem[8'h21], 8'h01);
    chk("ovl_22", mem[8'h22], 8'h01);
    chk("ovl_23", mem[8'h23], 8'h01);

    // Asynchronous reset during the first WR cycle of a copy.
    start = 1'b1; fill = 1'b0; src_addr = 8'h10; dst_addr = 8'h50; len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back(mk(1, 0, 1, 0, 8'h10, 8'h00));
    @(posedge clk); #1;
    #2 rst_n = 1'b0; start = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_wr", mem_write, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_wdata", mem_wdata, 0);
    repeat (3) @(negedge clk);
    #1 start = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arst_state", dbg_state, 0);
    chk("arst_d50_kept", mem[8'h50], 8'h6C);
    run_op(0, 8'h10, 8'h50, 8'd4, 8'h00, 0);
    chk("arst_copy_done", done_at, 9);
    chk("arst_d50", mem[8'h50], 8'hA1);
    chk("arst_d53", mem[8'h53], 8'hD4);

    // Whole-memory image against the model.
    for (int i = 0; i < 256; i++) chk("mem_image", mem[i], exp_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
